// File: rtl/burst_load_seq.sv
// Burst request sequencer: buffers (addr, len) requests and drives the load pair en/inp of a
// free-running address counter. Define BURST_LOAD_SEQ_ASSERT_EN to compile in the property checks.
module burst_load_seq #(
   parameter int W     = 16,
   parameter int LW    = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [W-1:0]             req_addr,
   input  logic [LW-1:0]            req_len,
   output logic                     en,
   output logic [W-1:0]             inp,
   output logic                     last_beat,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW  = $clog2(DEPTH);
   localparam int LVW = AW + 1;

   logic [W-1:0]  fifo_addr [DEPTH];
   logic [LW-1:0] fifo_len  [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] rem;

   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic [W-1:0]  head_addr;
   logic [LW-1:0] head_len;

   assign full      = (level == LVW'(DEPTH));
   assign empty     = (level == '0);
   assign req_ready = !full && !rst;
   assign push      = req_valid && req_ready;
   // A burst is finishing (or nothing is running): the head may load on this edge.
   assign pop       = (rem <= LW'(1)) && !empty;
   assign head_addr = fifo_addr[rd_ptr];
   assign head_len  = fifo_len[rd_ptr];
   assign busy      = (rem != '0) || !empty || en;

   // NOTE: the storage array has no reset; pointers and level define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= req_addr;
         fifo_len[wr_ptr]  <= req_len;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         en        <= 1'b0;
         inp       <= '0;
         last_beat <= 1'b0;
         rem       <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
      end else begin
         last_beat <= (rem == LW'(1));
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            if (head_len != '0) begin
               en  <= 1'b1;
               inp <= head_addr;
               rem <= head_len;
            end else begin
               en  <= 1'b0;
               rem <= '0;
            end
         end else begin
            en <= 1'b0;
            if (rem != '0)
               rem <= rem - LW'(1);
         end

         if (push)
            wr_ptr <= wr_ptr + AW'(1);

         case ({push, pop})
            2'b10:   level <= level + LVW'(1);
            2'b01:   level <= level - LVW'(1);
            default: level <= level;
         endcase
      end
   end

`ifdef BURST_LOAD_SEQ_ASSERT_EN
   a_en_after_rem: assert property (@(posedge clk) disable iff (rst)
      en |-> ($past(rem) <= LW'(1)));

   a_level_bound: assert property (@(posedge clk)
      level <= LVW'(DEPTH));

   // The reset edge itself clears inp, so the cycle right after reset is exempt.
   a_inp_hold: assert property (@(posedge clk) disable iff (rst)
      (!en && !$past(rst)) |-> $stable(inp));

   a_back_to_back: assert property (@(posedge clk) disable iff (rst)
      (last_beat && en) |-> ($past(rem) == LW'(1)));
`else
   // Property checks are excluded from this build.
`endif

endmodule

// File: tb/tb_burst_load_seq.sv
// Bench for burst_load_seq: a timeline model of the request queue checked every cycle,
// plus directed scenarios with hand-computed counter addresses.
module tb_burst_load_seq;

   localparam int W     = 16;
   localparam int LW    = 8;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [W-1:0]  req_addr = '0;
   logic [LW-1:0] req_len = '0;
   logic          en;
   logic [W-1:0]  inp;
   logic          last_beat;
   logic          busy;
   logic [$clog2(DEPTH):0] level;

   burst_load_seq #(.W(W), .LW(LW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .en        (en),
      .inp       (inp),
      .last_beat (last_beat),
      .busy      (busy),
      .level     (level)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      else
         n_pass++;
   endtask

   // Downstream counter: loads inp on en, otherwise advances by one (wraps modulo 2^W).
   logic [W-1:0] cnt;
   always @(posedge clk) begin
      if (rst)     cnt <= '0;
      else if (en) cnt <= inp;
      else         cnt <= cnt + 16'd1;
   end

   // Timeline model: a burst loaded for cycle t shows its last beat in cycle t+len (last_end);
   // the next head may load at the edge that ends cycle last_end-1.
   typedef struct {
      logic [W-1:0]  addr;
      logic [LW-1:0] len;
   } req_t;

   req_t       q[$];
   int         cyc      = 0;
   int         last_end = -100;
   bit         live     = 1'b0;
   logic       m_en     = 1'b0;
   logic [W-1:0] m_inp  = '0;
   logic       m_last   = 1'b0;

   always @(posedge clk) begin
      req_t h;
      bit   do_push;
      if (rst) begin
         q.delete();
         last_end = -100;
         m_en     = 1'b0;
         m_inp    = '0;
         m_last   = 1'b0;
         live     = 1'b1;
      end else begin
         do_push = req_valid && (q.size() < DEPTH);
         m_last  = (cyc == last_end - 1);
         m_en    = 1'b0;
         if ((cyc >= last_end - 1) && (q.size() > 0)) begin
            h = q.pop_front();
            if (h.len != 0) begin
               m_en     = 1'b1;
               m_inp    = h.addr;
               last_end = cyc + 1 + int'(h.len);
            end
         end
         if (do_push) q.push_back('{addr: req_addr, len: req_len});
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (live) begin
         check("en",        en,        m_en);
         check("inp",       inp,       m_inp);
         check("last_beat", last_beat, m_last);
         check("level",     level,     q.size());
         check("busy",      busy,      (cyc < last_end) || (q.size() != 0) || m_en);
         check("req_ready", req_ready, !rst && (q.size() < DEPTH));
      end
   end

   task automatic slot();
      @(negedge clk);
      #1;
   endtask

   task automatic push_req(input logic [W-1:0] a, input logic [LW-1:0] l);
      bit r;
      bit ok = 1'b0;
      req_valid = 1'b1;
      req_addr  = a;
      req_len   = l;
      for (int i = 0; i < 50; i++) begin
         r = req_ready;
         slot();
         if (r) begin
            ok = 1'b1;
            break;
         end
      end
      check("push_accepted", ok, 1'b1);
      req_valid = 1'b0;
   endtask

   task automatic wait_en();
      bit seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (en) begin
            seen = 1'b1;
            break;
         end
         slot();
      end
      check("en_seen", seen, 1'b1);
   endtask

   task automatic wait_idle();
      bit idle = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (!busy) begin
            idle = 1'b1;
            break;
         end
         slot();
      end
      check("idle_reached", idle, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int           waits;
      int           en_cnt;
      logic [W-1:0] got_inp;
      logic [W-1:0] exp5 [4];

      // Reset state
      rst = 1'b1;
      slot();
      check("ready_in_rst", req_ready, 1'b0);
      slot();
      check("rst_en",    en,        1'b0);
      check("rst_inp",   inp,       16'h0000);
      check("rst_last",  last_beat, 1'b0);
      check("rst_level", level,     3'd0);
      check("rst_busy",  busy,      1'b0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", req_ready, 1'b1);

      // Scenario 1: single burst of 3
      push_req(16'h8000, 8'd3);
      check("s1_level1", level, 3'd1);
      check("s1_no_en",  en,    1'b0);
      slot();
      check("s1_en",     en,    1'b1);
      check("s1_inp",    inp,   16'h8000);
      slot();
      check("s1_a0",     cnt,   16'h8000);
      slot();
      check("s1_a1",     cnt,   16'h8001);
      slot();
      check("s1_a2",     cnt,   16'h8002);
      check("s1_last",   last_beat, 1'b1);
      slot();
      check("s1_idle",   busy,  1'b0);

      // Scenario 2: back-to-back bursts, no gap
      push_req(16'h0010, 8'd2);
      push_req(16'h0100, 8'd1);
      check("s2_en0",    en,    1'b1);
      check("s2_inp0",   inp,   16'h0010);
      slot();
      check("s2_a10",    cnt,   16'h0010);
      slot();
      check("s2_a11",    cnt,   16'h0011);
      check("s2_en1",    en,    1'b1);
      check("s2_inp1",   inp,   16'h0100);
      check("s2_last0",  last_beat, 1'b1);
      slot();
      check("s2_a100",   cnt,   16'h0100);
      check("s2_last1",  last_beat, 1'b1);
      wait_idle();

      // Scenario 3: back-pressure while a long burst runs
      push_req(16'h4000, 8'd8);
      wait_en();
      for (int i = 0; i < 4; i++) push_req(16'h5000 + 16'(i), 8'd1);
      check("s3_full_level", level,     3'd4);
      check("s3_not_ready",  req_ready, 1'b0);
      req_valid = 1'b1;
      req_addr  = 16'h5004;
      req_len   = 8'd1;
      waits     = 0;
      for (int i = 0; i < 50; i++) begin
         bit r;
         r = req_ready;
         if (!r) waits++;
         slot();
         if (r) break;
      end
      req_valid = 1'b0;
      check("s3_wait_cycles", waits, 4);
      wait_idle();

      // Scenario 4: null request produces no load
      push_req(16'h1234, 8'd0);
      push_req(16'h2000, 8'd1);
      en_cnt  = 0;
      got_inp = '0;
      for (int i = 0; i < 8; i++) begin
         if (en) begin
            en_cnt++;
            got_inp = inp;
         end
         slot();
      end
      check("s4_en_count", en_cnt,  1);
      check("s4_inp",      got_inp, 16'h2000);
      wait_idle();

      // Scenario 5: address wrap
      exp5[0] = 16'hFFFE;
      exp5[1] = 16'hFFFF;
      exp5[2] = 16'h0000;
      exp5[3] = 16'h0001;
      push_req(16'hFFFE, 8'd4);
      wait_en();
      for (int k = 0; k < 4; k++) begin
         slot();
         check("s5_addr", cnt,       exp5[k]);
         check("s5_last", last_beat, (k == 3));
      end
      wait_idle();

      // Scenario 6: reset mid-burst with queued requests
      push_req(16'h3000, 8'd8);
      wait_en();
      push_req(16'h6000, 8'd2);
      push_req(16'h6100, 8'd2);
      push_req(16'h6200, 8'd2);
      check("s6_level3", level, 3'd3);
      check("s6_busy",   busy,  1'b1);
      rst = 1'b1;
      slot();
      check("s6_en",    en,    1'b0);
      check("s6_level", level, 3'd0);
      check("s6_busy0", busy,  1'b0);
      rst = 1'b0;
      #1;
      check("s6_ready", req_ready, 1'b1);
      en_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         if (en) en_cnt++;
         slot();
      end
      check("s6_no_en", en_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
